// File: rtl/and_unit_scheduler_pkg.sv
// Shared definitions for the AND-unit scheduler: state encoding and default sizes.
package and_unit_scheduler_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_WIDTH   = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/and_unit_scheduler_rr_arbiter.sv
// Combinational round-robin winner select, searching upward from ptr_i with wrap.
module and_unit_scheduler_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  int unsigned cand;

  // First requester at or after the pointer wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr_i) + k) % NUM_REQ;
      if (!any_o && req_i[ID_W'(cand)]) begin
        any_o = 1'b1;
        idx_o = ID_W'(cand);
      end
    end
    if (any_o) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/and_unit_scheduler.sv
// Shares one registered bitwise-AND unit among NUM_REQ requesters with
// round-robin arbitration and a response routed back to the winner.
module and_unit_scheduler
  import and_unit_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned ID_W    = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [WIDTH-1:0]  a_sel, b_sel;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;

  and_unit_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (arb_gnt[k]) begin
        a_sel = req_a[k*WIDTH +: WIDTH];
        b_sel = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
    end
  end

  // Handshakes are suppressed while reset is high so no transfer is seen to complete.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state_q)
      S_IDLE: begin
        if (arb_any && !reset) begin
          req_ready = arb_gnt;
          grant_d   = arb_idx;
          a_d       = a_sel;
          b_d       = b_sel;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        data_d  = a_q & b_q;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (!reset) begin
          rsp_valid[grant_q] = 1'b1;
          if (rsp_ready[grant_q]) begin
            state_d = S_IDLE;
            ptr_d   = (32'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + ID_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rsp_data = data_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_and_unit_scheduler.sv
// Randomized and directed bench for and_unit_scheduler against a transaction-level model.
module tb_and_unit_scheduler;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   rsp_data;
  logic [IW-1:0]  grant_id;
  logic           busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0 = waiting for a request, 1 = computing, 2 = answering.
  int         m_phase, m_ptr, m_gid;
  logic [W-1:0] m_data, m_a, m_b;
  int         dut_acc[$];

  always #5 clock = ~clock;

  and_unit_scheduler #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = $urandom;
    return r;
  endfunction

  // One clock cycle: drive, check outputs against the model, then advance the model.
  task automatic step(input logic rst, input logic [N-1:0] v, input logic [N*W-1:0] a,
                      input logic [N*W-1:0] b, input logic [N-1:0] rr);
    int win;
    logic [N-1:0] exp_rdy, exp_rv;
    reset = rst; req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
    #2;
    win = rr_pick(v, m_ptr);
    exp_rdy = '0;
    exp_rv  = '0;
    if (!rst && m_phase == 0 && win >= 0) exp_rdy[win] = 1'b1;
    if (!rst && m_phase == 2) exp_rv[m_gid] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    check("rsp_data",  64'(rsp_data),  64'(m_data));
    check("grant_id",  64'(grant_id),  64'(m_gid));
    check("busy",      64'(busy),      64'(m_phase != 0));
    for (int k = 0; k < N; k++) if (req_ready[k]) dut_acc.push_back(k);
    @(posedge clock);
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_gid = 0; m_data = '0;
    end else if (m_phase == 0) begin
      if (win >= 0) begin
        m_gid = win; m_a = a[win*W +: W]; m_b = b[win*W +: W]; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_data = m_a & m_b; m_phase = 2;
    end else if (rr[m_gid]) begin
      m_ptr = (m_gid + 1) % N; m_phase = 0;
    end
    #1;
  endtask

  initial begin
    logic [N*W-1:0] a, b;
    int exp_order[5];
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    repeat (2) @(posedge clock);
    #1;
    m_phase = 0; m_ptr = 0; m_gid = 0; m_data = '0; m_a = '0; m_b = '0;

    // Reset then idle.
    step(1'b1, '0, '0, '0, '0);
    repeat (3) step(1'b0, '0, rand_vec(), rand_vec(), '1);

    // Single request from requester 2.
    a = rand_vec(); b = rand_vec();
    a[2*W +: W] = 32'hF0F0_1234; b[2*W +: W] = 32'h0FF0_FFFF;
    step(1'b0, 4'b0100, a, b, '1);
    step(1'b0, 4'b0000, a, b, '1);
    check("single_rv", 64'(rsp_valid), 64'(4'b0100));
    check("single_rd", 64'(rsp_data), 64'h00F0_1234);
    step(1'b0, 4'b0000, a, b, '1);
    check("single_idle", 64'(busy), 64'd0);

    // Round-robin fairness from a fresh pointer.
    step(1'b1, '0, '0, '0, '0);
    dut_acc.delete();
    repeat (15) step(1'b0, 4'b1111, rand_vec(), rand_vec(), '1);
    exp_order = '{0, 1, 2, 3, 0};
    check("rr_count", 64'(dut_acc.size()), 64'd5);
    for (int k = 0; k < 5 && k < dut_acc.size(); k++)
      check($sformatf("rr_order%0d", k), 64'(dut_acc[k]), 64'(exp_order[k]));

    // Response backpressure with other requesters waiting.
    step(1'b0, 4'b0100, rand_vec(), rand_vec(), '0);
    step(1'b0, 4'b1011, rand_vec(), rand_vec(), '0);
    repeat (5) step(1'b0, 4'b1111, rand_vec(), rand_vec(), '0);
    check("bp_hold", 64'(busy), 64'd1);
    step(1'b0, 4'b1111, rand_vec(), rand_vec(), 4'b0100);
    check("bp_done", 64'(busy), 64'd0);

    // Wrong-requester ready does not complete the response.
    step(1'b1, '0, '0, '0, '0);
    step(1'b0, 4'b0010, rand_vec(), rand_vec(), '0);
    step(1'b0, 4'b0000, rand_vec(), rand_vec(), '0);
    repeat (3) step(1'b0, 4'b0000, rand_vec(), rand_vec(), 4'b0100);
    check("wrong_rdy_hold", 64'(rsp_valid), 64'(4'b0010));
    step(1'b0, 4'b0000, rand_vec(), rand_vec(), 4'b0010);
    check("right_rdy_done", 64'(busy), 64'd0);

    // Reset during EXEC discards the operation and clears the pointer.
    step(1'b0, 4'b1000, rand_vec(), rand_vec(), '1);
    step(1'b1, 4'b0000, rand_vec(), rand_vec(), '1);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_rv", 64'(rsp_valid), 64'd0);
    dut_acc.delete();
    step(1'b0, 4'b1010, rand_vec(), rand_vec(), '1);
    check("rst_mid_winner", 64'(dut_acc.size() > 0 ? dut_acc[0] : -1), 64'd1);

    // Random traffic with occasional resets and backpressure.
    for (int c = 0; c < 800; c++) begin
      step(($urandom_range(0, 63) == 0), N'($urandom), rand_vec(), rand_vec(), N'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/and_unit_scheduler.md
Name: and_unit_scheduler

Overview:
- Shares one registered bitwise-AND execution unit among NUM_REQ requesters.
- Round-robin arbitration, valid/ready request handshake, response routed back to the winning requester.
- Sits between the PD0 front-end requesters and the single registered logic unit; one operation in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width in bits
- ID_W, 2, grant index width; must equal clog2(NUM_REQ)

Ports:
- clock  in  1  system clock, posedge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing
- req_ready  out  NUM_REQ  one-hot accept strobe
- rsp_valid  out  NUM_REQ  one-hot response valid
- rsp_data  out  WIDTH  result, shared by all requesters
- rsp_ready  in  NUM_REQ  per-requester response accept
- grant_id  out  ID_W  index of current/last granted requester
- busy  out  1  high whenever state != IDLE

Behaviour:
- One clock; reset is synchronous and active-high, sampled on posedge clock.
- Reset values: state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, grant_id=0, busy=0, rr pointer=0 (requester 0 has highest priority after reset).
- States: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, pick the winner by round-robin, searching from pointer upward with wrap at NUM_REQ-1 -> 0.
  - req_ready[winner]=1 combinationally in the same cycle; handshake completes on that edge.
  - Latch a/b of the winner and grant_id=winner; go to EXEC.
  - No valid requests: stay in IDLE, outputs held.
- EXEC: rsp_data <= a & b (single registered stage); go to RESP. Latency is 2 cycles from accept edge to rsp_valid high.
- RESP:
  - rsp_valid[grant_id]=1, rsp_data stable.
  - On rsp_ready[grant_id]=1: return to IDLE and set pointer=(grant_id+1) mod NUM_REQ.
  - Otherwise hold indefinitely.
  - rsp_ready bits of other requesters are ignored.
- req_ready is 0 outside IDLE. New requests wait while busy; no queuing.
- A requester dropping req_valid before it is accepted is legal; no grant is issued to it.
- Simultaneous requests: exactly one winner. A requester that has just been served has lowest priority next time, so there is no starvation. Maximum wait for any requester is NUM_REQ-1 operations.
- Back-to-back: earliest re-grant is the cycle after RESP completes, giving a 3-cycle minimum per operation.
- Reset mid-operation (EXEC or RESP):
  - Next state is IDLE, rsp_valid=0, pointer=0.
  - The in-flight result is discarded with no response.
- rsp_data retains its last value in IDLE. It is valid only while rsp_valid is high.
- Pointer wrap: grant_id=NUM_REQ-1 completing sets pointer to 0.

Decomposition:
- Shared package/header holds:
  - State encoding constants S_IDLE=2'd0, S_EXEC=2'd1, S_RESP=2'd2.
  - Default NUM_REQ/WIDTH localparams.
- One sub-module, rr_arbiter:
  - Pure combinational round-robin winner select.
  - Inputs: request vector, pointer. Outputs: one-hot grant, grant index, any_grant.
- The scheduler top holds the FSM, operand registers, result register and pointer.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, no requests -> all outputs 0, busy=0, grant_id=0.
- Single request: req_valid=4'b0100, a=32'hF0F0_1234, b=32'h0FF0_FFFF, rsp_ready=1 -> req_ready=4'b0100 at cycle 0; rsp_valid=4'b0100 with rsp_data=32'h00F0_1234 at cycle 2; IDLE at cycle 3.
- Round-robin fairness: req_valid=4'b1111 held, rsp_ready=all 1 -> grant order 0,1,2,3,0. No requester is served twice before every other requester has been served once.
- Response backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, req_ready=0 throughout; accepted on the cycle rsp_ready[grant_id] rises.
- Wrong-requester ready: in RESP with grant_id=1, assert rsp_ready=4'b0100 -> no completion. Then assert 4'b0010 -> completes.
- Reset mid-op: assert reset during EXEC -> next cycle state IDLE, rsp_valid=0, no response issued. With req_valid=4'b1010 afterwards, requester 1 wins.
